// File: rtl/io_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_if
//  Description : Write-strobe bus between the core's port-write decode and
//                the io_port block.
//                  cePortDir  - load enable for the direction register
//                  portDir    - direction value (1 = OUTPUT, 0 = INPUT)
//                  cePortOut  - load enable for the data register
//                  portData   - WIDTH-bit data value
//                master : core side, drives all strobes and values
//                slave  : io_port side, receives them
//  Revision    : 1.0  initial release
// ============================================================================
interface io_port_if #(
  parameter int WIDTH = 8
);

  logic             cePortDir;
  logic             portDir;
  logic             cePortOut;
  logic [WIDTH-1:0] portData;

  modport master (
    output cePortDir,
    output portDir,
    output cePortOut,
    output portData
  );

  modport slave (
    input  cePortDir,
    input  portDir,
    input  cePortOut,
    input  portData
  );

endinterface : io_port_if
`default_nettype wire

// File: rtl/io_port.sv
`default_nettype none
// ============================================================================
//  Module      : io_port
//  Description : WIDTH-bit general-purpose output port with whole-vector
//                tri-state drive. A direction register and a data register
//                are loaded from the core through clock-enabled strobes.
//                The pins carry the data register while the direction is
//                OUTPUT and float (all Z) while it is INPUT.
//  Ports       : clk   - system clock, rising-edge active
//                rst   - synchronous reset, active-high, beats both enables
//                bus   - io_port_if slave: cePortDir/portDir/cePortOut/portData
//                out   - WIDTH-bit tri-state pins
//  Revision    : 1.0  initial release
// ============================================================================
module io_port #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  io_port_if.slave              bus,
  output wire       [WIDTH-1:0] out
);

  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: each register loads only on its own strobe. The data
  // register loads independently of direction, so a value written while
  // the port is INPUT is kept and shows up once the port turns OUTPUT.
  always_comb begin
    dir_d  = dir_q;
    data_d = data_q;
    if (bus.cePortDir) begin
      dir_d = bus.portDir;
    end
    if (bus.cePortOut) begin
      data_d = bus.portData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= 1'b0;
      data_q <= '0;
    end else begin
      dir_q  <= dir_d;
      data_q <= data_d;
    end
  end

  // Pins depend only on the registers, never directly on the bus inputs.
  assign out = dir_q ? data_q : {WIDTH{1'bz}};

endmodule : io_port
`default_nettype wire

// File: tb/tb_io_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_port
//  Description : Self-checking bench for io_port. Directed scenarios followed
//                by random strobe traffic, each compared against a small
//                behavioural model of the port's direction and data state.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_port;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  wire  [WIDTH-1:0] out;

  io_port_if #(.WIDTH(WIDTH)) bus ();

  io_port #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic             m_dir;
  logic [WIDTH-1:0] m_data;

  int total;
  int passed;
  int failed;

  // Expected pin value from the model: data when OUTPUT, floating when INPUT.
  function automatic logic [WIDTH-1:0] expected_out();
    if (m_dir) return m_data;
    return {WIDTH{1'bz}};
  endfunction

  task automatic check(input string tag);
    logic [WIDTH-1:0] exp;
    exp   = expected_out();
    total = total + 1;
    assert (out === exp) begin
      passed = passed + 1;
    end else begin
      failed = failed + 1;
      $error("FAIL %s observed=%b expected=%b", tag, out, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance past the edge, update the model,
  // then compare the pins.
  task automatic step(input logic             s_rst,
                      input logic             s_ced,
                      input logic             s_dir,
                      input logic             s_ceo,
                      input logic [WIDTH-1:0] s_data,
                      input string            tag);
    rst           = s_rst;
    bus.cePortDir = s_ced;
    bus.portDir   = s_dir;
    bus.cePortOut = s_ceo;
    bus.portData  = s_data;
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_dir  = 1'b0;
      m_data = '0;
    end else begin
      if (s_ced) m_dir  = s_dir;
      if (s_ceo) m_data = s_data;
    end
    check(tag);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    m_dir  = 1'b0;
    m_data = '0;
    rst           = 1'b1;
    bus.cePortDir = 1'b0;
    bus.portDir   = 1'b0;
    bus.cePortOut = 1'b0;
    bus.portData  = '0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "reset_idle");
    // Reset leaves data at zero: switching to OUTPUT shows 00
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, "dir_out_after_reset");
    if (out !== 8'h00) begin
      total = total + 1;
      failed = failed + 1;
      $error("FAIL reset_data observed=%h expected=00", out);
    end else begin
      total = total + 1;
      passed = passed + 1;
    end

    // Output write
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, "write_a5");
    // Hold without enable, portDir change ignored as well
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "hold_no_ceo");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h12, "hold_no_ced");

    // Switch to INPUT, then write while floating
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "dir_in");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, "write_while_in");

    // Back to OUTPUT: retained data appears, then a new write
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "dir_out_retained");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, "write_55");

    // Reset beats both enables
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, "reset_priority");
    // Same stimulus without reset: both registers load together
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h0F, "simultaneous");
    // Simultaneous INPUT + write
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, "simul_in_write");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "simul_back_out");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           8'($urandom),
           "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_io_port
`default_nettype wire
